// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - Opcode encodings for the eight ALU operations.
//   - FSM state encoding used by seq_alu.
//   - Helper that says whether an opcode needs the iterative datapath.
package alu_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MULTU = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Purely combinational logic/add/sub/slt unit.
// Ports:
//   op   : operation code (alu_pkg encodings; MULTU/DIVU give y = 0)
//   a, b : operands
//   y    : result
//   ovf  : signed overflow for ADD/SUB, 0 otherwise
//   cout : carry out of the adder; for SUB this is 1 when a >= b unsigned
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             ovf,
    output logic             cout
);

    logic             sub;
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH:0]   sum;
    logic             lt;
    logic             add_ovf;

    assign sub   = (op == OP_SUB) || (op == OP_SLT);
    assign b_inv = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_inv} + {{WIDTH{1'b0}}, sub};
    assign cout  = sum[WIDTH];

    // Sign comparison uses ~b rather than ~b+1 on purpose: subtracting the
    // most-negative value must flag overflow, and ~b keeps the true sign of -b.
    assign add_ovf = (a[WIDTH-1] == b_inv[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    // Signed less-than without relying on the (possibly overflowed) difference
    // when the operand signs differ.
    assign lt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_NOR: y = ~(a | b);
            OP_ADD: begin
                y   = sum[WIDTH-1:0];
                ovf = add_ovf;
            end
            OP_SUB: begin
                y   = sum[WIDTH-1:0];
                ovf = add_ovf;
            end
            OP_SLT: y = {{(WIDTH-1){1'b0}}, lt};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake for the multi-cycle core.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : request, sampled only in IDLE
//   aluop, a, b   : operation and operands, captured with an accepted start
//   busy          : high while MULTU/DIVU iterate
//   done          : one-cycle pulse, results valid in that cycle
//   lo, hi        : result / product halves / quotient and remainder
//   zero, ovf, dbz: lo == 0, signed ADD/SUB overflow, DIVU by zero
//
// Handshake: start is accepted on a rising edge while in IDLE. Single-cycle
// ops give done in the next cycle; MULTU/DIVU hold busy for WIDTH cycles and
// give done WIDTH+1 cycles after the start edge. start is ignored while busy
// and in the done cycle. Outputs hold until the next operation completes.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             dbz
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               dbz_pend;
    // MULTU: multiplicand. DIVU: divisor.
    logic [WIDTH-1:0]   opnd;
    // MULTU: {partial product high, multiplier/product low}.
    // DIVU:  {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_step;

    // Single-cycle result path.
    logic [WIDTH-1:0]   alu_y;
    logic               alu_ovf;
    logic               alu_cout;

    alu_comb #(.WIDTH(WIDTH)) u_alu (
        .op   (aluop),
        .a    (a),
        .b    (b),
        .y    (alu_y),
        .ovf  (alu_ovf),
        .cout (alu_cout)
    );

    // Restoring-division trial subtraction on a WIDTH+1-bit partial remainder.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           trial_ovf;
    logic           trial_ok;

    assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};

    alu_comb #(.WIDTH(WIDTH+1)) u_div_sub (
        .op   (OP_SUB),
        .a    (rem_shift),
        .b    ({1'b0, opnd}),
        .y    (trial),
        .ovf  (trial_ovf),
        .cout (trial_ok)
    );

    // The remainder never reaches 2^WIDTH, so the top trial bit is not needed.
    logic unused_bits;
    assign unused_bits = &{1'b0, alu_cout, trial_ovf, trial[WIDTH]};

    // Shift-add multiply step.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    always_comb begin
        if (is_div) begin
            acc_next = {(trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], trial_ok};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign last_step = (cnt == CNT_W'(1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = is_iter_op(aluop) ? S_ITER : S_DONE;
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            dbz_pend <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            lo       <= '0;
            hi       <= '0;
            zero     <= 1'b0;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_iter_op(aluop)) begin
                            is_div   <= (aluop == OP_DIVU);
                            dbz_pend <= (aluop == OP_DIVU) && (b == '0);
                            opnd     <= (aluop == OP_DIVU) ? b : a;
                            acc      <= {{WIDTH{1'b0}}, ((aluop == OP_DIVU) ? a : b)};
                            cnt      <= CNT_W'(WIDTH);
                        end else begin
                            lo   <= alu_y;
                            hi   <= '0;
                            zero <= (alu_y == '0);
                            ovf  <= alu_ovf;
                            dbz  <= 1'b0;
                        end
                    end
                end
                S_ITER: begin
                    acc <= acc_next;
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        lo   <= acc_next[WIDTH-1:0];
                        hi   <= acc_next[2*WIDTH-1:WIDTH];
                        zero <= (acc_next[WIDTH-1:0] == '0);
                        ovf  <= 1'b0;
                        dbz  <= dbz_pend;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
